// File: rtl/fft32_bfly_sched.sv
// Butterfly address scheduler for an in-place 32-point radix-2 DIT FFT.
// Optional issue stall port when FFT_SCHED_STALL_EN is defined.
module fft32_bfly_sched #(
  parameter int LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef FFT_SCHED_STALL_EN
  input  logic       stall,
`endif
  output logic       busy,
  output logic       done,
  output logic [2:0] stage,
  output logic       rd_en,
  output logic [4:0] rd_addr_a,
  output logic [4:0] rd_addr_b,
  output logic [3:0] tw_idx,
  output logic       wr_en,
  output logic [4:0] wr_addr_a,
  output logic [4:0] wr_addr_b
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [1:0]    state;
  logic [3:0]    k;
  logic [2:0]    stage_c;
  logic [DW-1:0] dcnt;
  logic          hold;

  logic [4:0] mask;
  logic [4:0] kx;
  logic [4:0] addr_a;
  logic [4:0] addr_b;
  logic [3:0] pos;
  logic [3:0] tw;

  logic [10:0] pipe [LAT];

`ifdef FFT_SCHED_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  // Pair addresses and twiddle for butterfly k of the current stage.
  always_comb begin
    mask   = 5'((5'd1 << stage_c) - 5'd1);
    kx     = {1'b0, k};
    addr_a = ((kx & ~mask) << 1) | (kx & mask);
    addr_b = addr_a + 5'(mask + 5'd1);
    pos    = 4'(kx & mask);
    tw     = 4'(pos << (3'd4 - stage_c));
  end

  // Pass sequencing plus registered read-side outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      stage_c   <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
    end else begin
      rd_en <= 1'b0;
      busy  <= (state == RUN) || (state == DRAIN);
      done  <= (state == DONE);
      stage <= stage_c;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            k       <= '0;
            stage_c <= '0;
          end
        end
        RUN: begin
          if (!hold) begin
            rd_en     <= 1'b1;
            rd_addr_a <= addr_a;
            rd_addr_b <= addr_b;
            tw_idx    <= tw;
            if (k == 4'd15) begin
              state <= DRAIN;
              dcnt  <= '0;
            end else begin
              k <= k + 4'd1;
            end
          end
        end
        DRAIN: begin
          if (dcnt == DW'(LAT - 1)) begin
            if (stage_c == 3'd4) begin
              state <= DONE;
            end else begin
              stage_c <= stage_c + 3'd1;
              k       <= '0;
              state   <= RUN;
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write-back delay line; shifts every cycle so issued writes always land.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {wr_en, wr_addr_a, wr_addr_b} = pipe[LAT-1];

endmodule

// File: tb/tb_fft32_bfly_sched.sv
// Directed bench for fft32_bfly_sched with LAT=2.
// Stall scenario runs only when FFT_SCHED_STALL_EN is defined.
module tb_fft32_bfly_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stall;
  logic       busy;
  logic       done;
  logic [2:0] stage;
  logic       rd_en;
  logic [4:0] rd_addr_a;
  logic [4:0] rd_addr_b;
  logic [3:0] tw_idx;
  logic       wr_en;
  logic [4:0] wr_addr_a;
  logic [4:0] wr_addr_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fft32_bfly_sched #(.LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef FFT_SCHED_STALL_EN
    .stall     (stall),
`endif
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_idx    (tw_idx),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Reference read issue for cycle c of an unstalled pass: {en,a,b,tw}.
  function automatic logic [14:0] model(input int c);
    int s, j, span, grp, p, a, b, t;
    logic [14:0] r;
    r = '0;
    if (c >= 1 && c <= 90) begin
      s = (c - 1) / 18;
      j = (c - 1) % 18;
      if (j < 16) begin
        span = 1 << s;
        grp  = j / span;
        p    = j % span;
        a    = grp * 2 * span + p;
        b    = a + span;
        t    = p * (16 / span);
        r    = {1'b1, a[4:0], b[4:0], t[3:0]};
      end
    end
    return r;
  endfunction

  initial begin
    logic [14:0] m;
    int done_cnt;
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_addr", {rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b}, 0);
    check("rst_stage", stage, 0);

    // Full pass: start sampled at edge 0, second start at edge 20.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("c0_busy", busy, 0);
    for (int c = 1; c <= 95; c++) begin
      if (c == 20) start = 1'b1;
      tick();
      start = 1'b0;
      m = model(c);
      check($sformatf("rd_en@%0d", c), rd_en, m[14]);
      if (m[14]) begin
        check($sformatf("rd_addr@%0d", c),
              {rd_addr_a, rd_addr_b, tw_idx}, m[13:0]);
      end
      m = model(c - 2);
      check($sformatf("wr_en@%0d", c), wr_en, m[14]);
      if (m[14]) begin
        check($sformatf("wr_addr@%0d", c),
              {wr_addr_a, wr_addr_b}, m[13:4]);
      end
      check($sformatf("done@%0d", c), done, (c == 91));
      check($sformatf("busy@%0d", c), busy, (c <= 90));
      if (c == 1) begin
        check("c1_a", rd_addr_a, 0);
        check("c1_b", rd_addr_b, 1);
        check("c1_tw", tw_idx, 0);
      end
      if (c == 6) begin
        check("c6_a", rd_addr_a, 10);
        check("c6_b", rd_addr_b, 11);
      end
      if (c == 8) begin
        check("c8_wr_a", wr_addr_a, 10);
        check("c8_wr_b", wr_addr_b, 11);
      end
      if (c == 42) begin
        check("s2k5_stage", stage, 2);
        check("s2k5_a", rd_addr_a, 9);
        check("s2k5_b", rd_addr_b, 13);
        check("s2k5_tw", tw_idx, 4);
      end
      if (c == 88) begin
        check("s4k15_stage", stage, 4);
        check("s4k15_a", rd_addr_a, 15);
        check("s4k15_b", rd_addr_b, 31);
        check("s4k15_tw", tw_idx, 15);
      end
    end

    // Reset at edge 40 of a new pass aborts it.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 40; c++) tick();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_wr", {wr_en, wr_addr_a, wr_addr_b}, 0);
    check("mid_rst_addr", {rd_addr_a, rd_addr_b, tw_idx}, 0);
    check("mid_rst_stage", stage, 0);
    done_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (wr_en || done || busy) done_cnt++;
    end
    check("post_rst_quiet", done_cnt, 0);

`ifdef FFT_SCHED_STALL_EN
    // Stall at edges 22..24 (stage 1) delays done to cycle 94.
    start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 96; c++) begin
      stall = (c >= 22 && c <= 24);
      tick();
      stall = 1'b0;
      if (c >= 22 && c <= 24) begin
        check($sformatf("stall_rd_en@%0d", c), rd_en, 0);
        check($sformatf("stall_stage@%0d", c), stage, 1);
      end
      if (c == 21) check("pre_stall_a", rd_addr_a, 4);
      if (c == 25) begin
        check("post_stall_a", rd_addr_a, 5);
        check("post_stall_b", rd_addr_b, 7);
        check("post_stall_tw", tw_idx, 8);
      end
      check($sformatf("stall_done@%0d", c), done, (c == 94));
      if (done) done_cnt++;
    end
    check("stall_done_cnt", done_cnt, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
